// File: rtl/k_means_point_buffer.sv
// Point RAM plus streamer: the host fills and reads back points while idle, and each
// start streams points 0..N-1 to the k-means core through a 2-entry output FIFO.
module k_means_point_buffer #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 91
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 host_wr_en,
  input  logic [addrWidth-1:0] host_addr,
  input  logic [dataWidth-1:0] host_wr_data,
  input  logic                 host_rd_en,
  output logic [dataWidth-1:0] host_rd_data,
  input  logic [addrWidth:0]   num_points,
  input  logic                 start,
  output logic                 busy,
  output logic                 point_valid,
  input  logic                 point_ready,
  output logic [dataWidth-1:0] point_data,
  output logic [addrWidth-1:0] point_index,
  output logic                 point_last,
  output logic                 pass_done,
  output logic                 wr_err,
  input  logic                 wr_err_clr
);

  localparam int DEPTH = 1 << addrWidth;
  localparam logic [addrWidth:0] MAX_N = (addrWidth+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  function automatic logic [addrWidth:0] sat_count(input logic [addrWidth:0] n);
    return (n > MAX_N) ? MAX_N : n;
  endfunction

  state_t               r_state;
  logic [addrWidth:0]   r_n;
  logic [addrWidth:0]   r_issue_cnt;
  logic [addrWidth:0]   r_acc_cnt;
  logic                 r_pass_done;
  logic                 r_wr_err;
  logic [dataWidth-1:0] r_host_rd_data;
  logic [dataWidth-1:0] r_mem [DEPTH];

  logic [dataWidth-1:0] r_rd_data_p0;
  logic                 r_rd_vld_p0;
  logic [dataWidth-1:0] r_fifo [2];
  logic                 r_wptr;
  logic                 r_rptr;
  logic [1:0]           r_cnt;

  logic                 w_busy;
  logic                 w_host_wr;
  logic                 w_host_rd;
  logic                 w_valid;
  logic                 w_hs;
  logic                 w_last;
  logic                 w_issue;
  logic [2:0]           w_used;
  logic [addrWidth:0]   w_n_sat;

  assign w_busy    = (r_state != IDLE);
  assign w_host_wr = host_wr_en & ~w_busy;
  assign w_host_rd = host_rd_en & ~w_busy;
  assign w_valid   = (r_cnt != 2'd0);
  assign w_hs      = w_valid & point_ready;
  assign w_last    = (r_acc_cnt == r_n - (addrWidth+1)'(1));
  assign w_n_sat   = sat_count(num_points);

  // A pop in the same cycle frees a slot, which keeps one point per cycle flowing.
  assign w_used  = {1'b0, r_cnt} + {2'b00, r_rd_vld_p0};
  assign w_issue = (r_state == STREAM) && (r_issue_cnt < r_n) &&
                   (w_used < (3'd2 + {2'b00, w_hs}));

  assign busy         = w_busy;
  assign point_valid  = w_valid;
  assign point_data   = w_valid ? r_fifo[r_rptr] : '0;
  assign point_index  = w_valid ? r_acc_cnt[addrWidth-1:0] : '0;
  assign point_last   = w_valid & w_last;
  assign pass_done    = r_pass_done;
  assign wr_err       = r_wr_err;
  assign host_rd_data = r_host_rd_data;

  always_ff @(posedge clk) begin
    if (w_host_wr) r_mem[host_addr] <= host_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_host_rd_data <= '0;
    else if (w_host_rd) r_host_rd_data <= r_mem[host_addr];
  end

  // Stage p0: streaming RAM read, one cycle ahead of the FIFO
  always_ff @(posedge clk) begin
    if (w_issue) r_rd_data_p0 <= r_mem[r_issue_cnt[addrWidth-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_vld_p0 <= 1'b0;
    else        r_rd_vld_p0 <= w_issue;
  end

  // Output FIFO: data storage is not reset, the outputs are gated by valid instead
  always_ff @(posedge clk) begin
    if (r_rd_vld_p0) r_fifo[r_wptr] <= r_rd_data_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (r_rd_vld_p0) r_wptr <= ~r_wptr;
      if (w_hs)        r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + 2'(r_rd_vld_p0) - 2'(w_hs);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_n         <= '0;
      r_issue_cnt <= '0;
      r_acc_cnt   <= '0;
      r_pass_done <= 1'b0;
    end else begin
      r_pass_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_n         <= w_n_sat;
            r_issue_cnt <= '0;
            r_acc_cnt   <= '0;
            if (w_n_sat == '0) begin
              r_state     <= DONE;
              r_pass_done <= 1'b1;
            end else begin
              r_state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (w_issue) r_issue_cnt <= r_issue_cnt + (addrWidth+1)'(1);
          if (w_hs) begin
            r_acc_cnt <= r_acc_cnt + (addrWidth+1)'(1);
            if (w_last) begin
              r_state     <= DONE;
              r_pass_done <= 1'b1;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // A dropped access outranks a clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_wr_err <= 1'b0;
    else if (w_busy && (host_wr_en || host_rd_en)) r_wr_err <= 1'b1;
    else if (wr_err_clr)                         r_wr_err <= 1'b0;
  end

endmodule
